ber_stats_aggregator: RTL and testbench

- Parametrised per-channel BER statistics engine, generalising the fixed two-emulator counter set now probed by the debug VIO.
- Accumulates frame count, last-frame errors/bits and saturating 64-bit error/bit totals for NUM_CH traffic checkers.
- Freezes all channels coherently into shadow registers on a snapshot request or an automatic period.
- Presents the selected channel's shadow to VIO probe_in ports, so the VIO width no longer scales with channel count.

---
 rtl/ber_stats_pkg.sv | 50 +++++
 rtl/ber_stats_channel.sv | 77 +++++++
 rtl/ber_stats_aggregator.sv | 121 ++++++++++++
 tb/tb_ber_stats_aggregator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_stats_pkg.sv
// -----------------------------------------------------------------------------
// ber_stats_pkg
// Shared types and helpers for the BER statistics aggregator.
//   ch_rec_t   : one channel's counter set (live or shadow copy). Fields are
//                sized for the widest supported build (CNT_W <= 32,
//                ACC_W <= 64). Narrower builds keep the unused upper bits at 0.
//   sat_add()  : unsigned add that clamps at 2^w-1 and reports the clamp.
//   SNAP_CNT_W : width of the wrapping snapshot counter.
// -----------------------------------------------------------------------------
package ber_stats_pkg;

    localparam int SNAP_CNT_W = 16;
    localparam int MAX_CNT_W  = 32;
    localparam int MAX_ACC_W  = 64;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] frames;
        logic [MAX_CNT_W-1:0] last_err;
        logic [MAX_CNT_W-1:0] last_bits;
        logic [MAX_ACC_W-1:0] acc_err;
        logic [MAX_ACC_W-1:0] acc_bits;
        logic                 sat;
    } ch_rec_t;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_ACC_W-1:0] sum;
    } sat_sum_t;

    // Both operands must already be below 2^w. The extra carry bit lets the
    // comparison against the w-bit limit work for w up to MAX_ACC_W.
    function automatic sat_sum_t sat_add(input logic [MAX_ACC_W-1:0] a,
                                         input logic [MAX_ACC_W-1:0] b,
                                         input int                   w);
        logic [MAX_ACC_W:0] full;
        logic [MAX_ACC_W:0] lim;
        sat_sum_t           r;
        full = {1'b0, a} + {1'b0, b};
        lim  = ((MAX_ACC_W+1)'(1) << w) - (MAX_ACC_W+1)'(1);
        if (full > lim) begin
            r.ovf = 1'b1;
            r.sum = lim[MAX_ACC_W-1:0];
        end else begin
            r.ovf = 1'b0;
            r.sum = full[MAX_ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ber_stats_channel.sv
// -----------------------------------------------------------------------------
// ber_stats_channel
// One checker channel: live counters updated per finished frame, plus a
// shadow copy frozen on snap.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_done        : one-cycle pulse, frame_errors/frame_bits valid
//   frame_errors/bits : per-frame results, CNT_W bits
//   clear             : one-cycle clear of live counters (wins over frame_done)
//   snap              : one-cycle copy of live (pre-update) values to shadow
//   shadow            : current shadow record
// -----------------------------------------------------------------------------
module ber_stats_channel
    import ber_stats_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done,
    input  logic [CNT_W-1:0] frame_errors,
    input  logic [CNT_W-1:0] frame_bits,
    input  logic             clear,
    input  logic             snap,
    output ch_rec_t          shadow
);

    localparam logic [MAX_CNT_W-1:0] FRAMES_MAX =
        {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - CNT_W);

    ch_rec_t  live_q, live_d;
    ch_rec_t  shadow_q, shadow_d;
    sat_sum_t err_sum, bits_sum;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        err_sum  = sat_add(MAX_ACC_W'(frame_errors), live_q.acc_err, ACC_W);
        bits_sum = sat_add(MAX_ACC_W'(frame_bits), live_q.acc_bits, ACC_W);
        live_d   = live_q;
        shadow_d = shadow_q;

        if (clear) begin
            live_d = '0;
        end else if (frame_done) begin
            live_d.frames    = (live_q.frames == FRAMES_MAX) ? live_q.frames
                                                             : live_q.frames + 1'b1;
            live_d.last_err  = MAX_CNT_W'(frame_errors);
            live_d.last_bits = MAX_CNT_W'(frame_bits);
            live_d.acc_err   = err_sum.sum;
            live_d.acc_bits  = bits_sum.sum;
            live_d.sat       = live_q.sat | err_sum.ovf | bits_sum.ovf;
        end

        // Shadow takes live_q, i.e. the values before this cycle's
        // clear or frame update.
        if (snap) begin
            shadow_d = live_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/ber_stats_aggregator.sv
// -----------------------------------------------------------------------------
// ber_stats_aggregator
// Per-channel BER statistics for NUM_CH traffic checkers, frozen coherently
// into shadow registers and shown one channel at a time to the VIO.
// Ports:
//   hb0_gtwiz_userclk_tx_usrclk2_int : sole clock
//   sys_reset                : synchronous active-high reset
//   frame_done[NUM_CH]       : per-channel frame-result strobe
//   frame_errors/frame_bits  : packed per-channel results, ch i at [i*CNT_W +: CNT_W]
//   error_accumulator_clear  : VIO level, rising edge clears live counters
//   snapshot_req             : VIO level, rising edge takes a snapshot
//   ch_sel                   : channel shown on the outputs (>= NUM_CH reads 0)
//   num_frames_recvd .. acc_saturated : registered shadow of selected channel
//   snapshot_count           : wrapping count of snapshots taken
// -----------------------------------------------------------------------------
module ber_stats_aggregator
    import ber_stats_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int CNT_W            = 32,
    parameter int ACC_W            = 64,
    parameter int SEL_W            = 4,
    parameter int AUTO_SNAP_PERIOD = 0
) (
    input  logic                    hb0_gtwiz_userclk_tx_usrclk2_int,
    input  logic                    sys_reset,
    input  logic [NUM_CH-1:0]       frame_done,
    input  logic [NUM_CH*CNT_W-1:0] frame_errors,
    input  logic [NUM_CH*CNT_W-1:0] frame_bits,
    input  logic                    error_accumulator_clear,
    input  logic                    snapshot_req,
    input  logic [SEL_W-1:0]        ch_sel,
    output logic [CNT_W-1:0]        num_frames_recvd,
    output logic [CNT_W-1:0]        num_errors_this_fr,
    output logic [CNT_W-1:0]        total_bits_this_fr,
    output logic [ACC_W-1:0]        accumulated_error,
    output logic [ACC_W-1:0]        total_bits_accumulated,
    output logic                    acc_saturated,
    output logic [SNAP_CNT_W-1:0]   snapshot_count
);

    localparam int          PER_W    = 32;
    localparam logic [PER_W-1:0] PER_LAST =
        (AUTO_SNAP_PERIOD == 0) ? '0 : PER_W'(AUTO_SNAP_PERIOD - 1);

    logic                  clr_prev_q, clr_prev_d;
    logic                  snap_prev_q, snap_prev_d;
    logic [PER_W-1:0]      period_q, period_d;
    logic [SNAP_CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    ch_rec_t               out_q, out_d;

    logic                  clear_edge;
    logic                  auto_tick;
    logic                  snap;
    ch_rec_t               shadow [NUM_CH];

    always_comb begin
        clr_prev_d  = error_accumulator_clear;
        snap_prev_d = snapshot_req;
        clear_edge  = error_accumulator_clear & ~clr_prev_q;
        auto_tick   = (AUTO_SNAP_PERIOD != 0) && (period_q == PER_LAST);
        // A manual edge and an auto tick in one cycle collapse into one snapshot.
        snap        = (snapshot_req & ~snap_prev_q) | auto_tick;

        if (AUTO_SNAP_PERIOD == 0 || auto_tick) begin
            period_d = '0;
        end else begin
            period_d = period_q + PER_W'(1);
        end

        snap_cnt_d = snap ? snap_cnt_q + SNAP_CNT_W'(1) : snap_cnt_q;

        out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                out_d = shadow[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ber_stats_channel #(
            .CNT_W (CNT_W),
            .ACC_W (ACC_W)
        ) u_ch (
            .clk          (hb0_gtwiz_userclk_tx_usrclk2_int),
            .rst          (sys_reset),
            .frame_done   (frame_done[g]),
            .frame_errors (frame_errors[g*CNT_W +: CNT_W]),
            .frame_bits   (frame_bits[g*CNT_W +: CNT_W]),
            .clear        (clear_edge),
            .snap         (snap),
            .shadow       (shadow[g])
        );
    end

    always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int) begin
        if (sys_reset) begin
            clr_prev_q  <= 1'b0;
            snap_prev_q <= 1'b0;
            period_q    <= '0;
            snap_cnt_q  <= '0;
            out_q       <= '0;
        end else begin
            clr_prev_q  <= clr_prev_d;
            snap_prev_q <= snap_prev_d;
            period_q    <= period_d;
            snap_cnt_q  <= snap_cnt_d;
            out_q       <= out_d;
        end
    end

    assign num_frames_recvd       = out_q.frames[CNT_W-1:0];
    assign num_errors_this_fr     = out_q.last_err[CNT_W-1:0];
    assign total_bits_this_fr     = out_q.last_bits[CNT_W-1:0];
    assign accumulated_error      = out_q.acc_err[ACC_W-1:0];
    assign total_bits_accumulated = out_q.acc_bits[ACC_W-1:0];
    assign acc_saturated          = out_q.sat;
    assign snapshot_count         = snap_cnt_q;

endmodule

// File: tb/tb_ber_stats_aggregator.sv
// -----------------------------------------------------------------------------
// tb_ber_stats_aggregator
// Three instances share one stimulus stream: dut_a (defaults), dut_s
// (ACC_W=36, saturation) and dut_p (AUTO_SNAP_PERIOD=8). Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ber_stats_aggregator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_reset;
    logic [1:0]  frame_done;
    logic [63:0] frame_errors;
    logic [63:0] frame_bits;
    logic        clr;
    logic        snap_req;
    logic [3:0]  ch_sel;

    logic [31:0] a_frames, a_last_err, a_last_bits;
    logic [63:0] a_acc_err, a_acc_bits;
    logic        a_sat;
    logic [15:0] a_cnt;

    logic [31:0] s_frames, s_last_err, s_last_bits;
    logic [35:0] s_acc_err, s_acc_bits;
    logic        s_sat;
    logic [15:0] s_cnt;

    logic [31:0] p_frames, p_last_err, p_last_bits;
    logic [63:0] p_acc_err, p_acc_bits;
    logic        p_sat;
    logic [15:0] p_cnt;

    ber_stats_aggregator dut_a (
        .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
        .sys_reset               (sys_reset),
        .frame_done              (frame_done),
        .frame_errors            (frame_errors),
        .frame_bits              (frame_bits),
        .error_accumulator_clear (clr),
        .snapshot_req            (snap_req),
        .ch_sel                  (ch_sel),
        .num_frames_recvd        (a_frames),
        .num_errors_this_fr      (a_last_err),
        .total_bits_this_fr      (a_last_bits),
        .accumulated_error       (a_acc_err),
        .total_bits_accumulated  (a_acc_bits),
        .acc_saturated           (a_sat),
        .snapshot_count          (a_cnt)
    );

    ber_stats_aggregator #(.ACC_W(36)) dut_s (
        .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
        .sys_reset               (sys_reset),
        .frame_done              (frame_done),
        .frame_errors            (frame_errors),
        .frame_bits              (frame_bits),
        .error_accumulator_clear (clr),
        .snapshot_req            (snap_req),
        .ch_sel                  (ch_sel),
        .num_frames_recvd        (s_frames),
        .num_errors_this_fr      (s_last_err),
        .total_bits_this_fr      (s_last_bits),
        .accumulated_error       (s_acc_err),
        .total_bits_accumulated  (s_acc_bits),
        .acc_saturated           (s_sat),
        .snapshot_count          (s_cnt)
    );

    ber_stats_aggregator #(.AUTO_SNAP_PERIOD(8)) dut_p (
        .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
        .sys_reset               (sys_reset),
        .frame_done              (frame_done),
        .frame_errors            (frame_errors),
        .frame_bits              (frame_bits),
        .error_accumulator_clear (clr),
        .snapshot_req            (snap_req),
        .ch_sel                  (ch_sel),
        .num_frames_recvd        (p_frames),
        .num_errors_this_fr      (p_last_err),
        .total_bits_this_fr      (p_last_bits),
        .accumulated_error       (p_acc_err),
        .total_bits_accumulated  (p_acc_bits),
        .acc_saturated           (p_sat),
        .snapshot_count          (p_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  fd;
        logic [31:0] e0, b0, e1, b1;
        logic        clr, snap;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] x_frames, x_last_err, x_last_bits;
        logic [63:0] x_acc_err, x_acc_bits;
        logic        x_sat;
        logic [15:0] x_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] fd, input logic [31:0] e0, input logic [31:0] b0,
                                input logic [31:0] e1, input logic [31:0] b1,
                                input logic c, input logic s, input logic [3:0] sel, input logic chk,
                                input logic [31:0] xf, input logic [31:0] xle, input logic [31:0] xlb,
                                input logic [63:0] xae, input logic [63:0] xab, input logic xs,
                                input logic [15:0] xc);
        vec_t v;
        v.fd = fd; v.e0 = e0; v.b0 = b0; v.e1 = e1; v.b1 = b1;
        v.clr = c; v.snap = s; v.sel = sel; v.chk = chk;
        v.x_frames = xf; v.x_last_err = xle; v.x_last_bits = xlb;
        v.x_acc_err = xae; v.x_acc_bits = xab; v.x_sat = xs; v.x_cnt = xc;
        return v;
    endfunction

    task automatic idle();
        frame_done   = 2'b00;
        frame_errors = '0;
        frame_bits   = '0;
        clr          = 1'b0;
        snap_req     = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle frame pulse, applied from a falling edge.
    task automatic pulse(input logic [1:0] fd, input logic [31:0] e0, input logic [31:0] b0,
                         input logic [31:0] e1, input logic [31:0] b1);
        frame_done   = fd;
        frame_errors = {e1, e0};
        frame_bits   = {b1, b0};
        settle();
        idle();
    endtask

    task automatic snapshot();
        snap_req = 1'b1;
        settle();
        snap_req = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " frames"},   a_frames,    '0);
        check({tag, " last_err"}, a_last_err,  '0);
        check({tag, " acc_err"},  a_acc_err,   '0);
        check({tag, " acc_bits"}, a_acc_bits,  '0);
        check({tag, " sat"},      a_sat,       '0);
    endtask

    vec_t vecs [13];

    initial begin
        // ---- directed table for dut_a -----------------------------------
        //            fd     e0  b0    e1  b1   clr  snp sel chk  frm le  lb    ae  ab    sat cnt
        vecs[0]  = mk(2'b01, 5,  1000, 0,  0,   0,   0,  0,  0,   0,  0,  0,    0,  0,    0,  0);
        vecs[1]  = mk(2'b01, 0,  1000, 0,  0,   0,   0,  0,  0,   0,  0,  0,    0,  0,    0,  0);
        vecs[2]  = mk(2'b01, 7,  1000, 0,  0,   0,   0,  0,  0,   0,  0,  0,    0,  0,    0,  0);
        vecs[3]  = mk(2'b00, 0,  0,    0,  0,   0,   1,  0,  1,   3,  7,  1000, 12, 3000, 0,  1);
        vecs[4]  = mk(2'b00, 0,  0,    0,  0,   0,   0,  1,  1,   0,  0,  0,    0,  0,    0,  1);
        vecs[5]  = mk(2'b01, 9,  100,  0,  0,   1,   0,  0,  1,   3,  7,  1000, 12, 3000, 0,  1);
        vecs[6]  = mk(2'b00, 0,  0,    0,  0,   0,   1,  0,  1,   0,  0,  0,    0,  0,    0,  2);
        vecs[7]  = mk(2'b10, 0,  0,    10, 500, 0,   0,  1,  1,   0,  0,  0,    0,  0,    0,  2);
        vecs[8]  = mk(2'b10, 0,  0,    4,  200, 0,   1,  1,  1,   1,  10, 500,  10, 500,  0,  3);
        vecs[9]  = mk(2'b00, 0,  0,    0,  0,   0,   1,  1,  1,   2,  4,  200,  14, 700,  0,  4);
        vecs[10] = mk(2'b01, 3,  64,   0,  0,   0,   0,  2,  1,   0,  0,  0,    0,  0,    0,  4);
        vecs[11] = mk(2'b00, 0,  0,    0,  0,   0,   1,  2,  1,   0,  0,  0,    0,  0,    0,  5);
        vecs[12] = mk(2'b00, 0,  0,    0,  0,   0,   0,  0,  1,   1,  3,  64,   3,  64,   0,  5);

        idle();
        ch_sel    = 4'd0;
        sys_reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_reset = 1'b0;

        // ---- reset state ------------------------------------------------
        check_a_zero("reset");
        check("reset last_bits", a_last_bits, '0);
        check("reset snap_cnt",  a_cnt, '0);
        check("reset p_cnt",     p_cnt, '0);

        // ---- automatic period: 40 idle cycles -> 5 snapshots -----------
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("auto 40 cycles p_cnt", p_cnt, 16'd5);
        check("auto off a_cnt",       a_cnt, 16'd0);
        // Next auto tick is on the 48th edge; line a manual edge up with it.
        repeat (7) @(posedge clk);
        @(negedge clk);
        snap_req = 1'b1;
        settle();
        check("manual+auto p_cnt", p_cnt, 16'd6);
        check("manual a_cnt",      a_cnt, 16'd1);
        snap_req = 1'b0;

        sys_reset = 1'b1;
        settle();
        sys_reset = 1'b0;

        // ---- table ------------------------------------------------------
        for (int i = 0; i < 13; i++) begin
            frame_done   = vecs[i].fd;
            frame_errors = {vecs[i].e1, vecs[i].e0};
            frame_bits   = {vecs[i].b1, vecs[i].b0};
            clr          = vecs[i].clr;
            snap_req     = vecs[i].snap;
            ch_sel       = vecs[i].sel;
            settle();
            idle();
            settle();
            if (vecs[i].chk) begin
                check($sformatf("v%0d frames", i),    a_frames,    vecs[i].x_frames);
                check($sformatf("v%0d last_err", i),  a_last_err,  vecs[i].x_last_err);
                check($sformatf("v%0d last_bits", i), a_last_bits, vecs[i].x_last_bits);
                check($sformatf("v%0d acc_err", i),   a_acc_err,   vecs[i].x_acc_err);
                check($sformatf("v%0d acc_bits", i),  a_acc_bits,  vecs[i].x_acc_bits);
                check($sformatf("v%0d sat", i),       a_sat,       vecs[i].x_sat);
                check($sformatf("v%0d snap_cnt", i),  a_cnt,       vecs[i].x_cnt);
            end
        end

        // ---- mux latency: exactly one cycle after ch_sel changes -------
        ch_sel = 4'd1;
        settle();
        check("sel1 frames",  a_frames,  32'd2);
        check("sel1 acc_err", a_acc_err, 64'd14);
        ch_sel = 4'd2;
        settle();
        check("sel2 acc_err", a_acc_err, 64'd0);
        check("sel2 frames",  a_frames,  32'd0);
        ch_sel = 4'd0;
        settle();
        check("sel0 frames",  a_frames,  32'd1);
        check("sel0 acc_err", a_acc_err, 64'd3);

        // ---- reset mid-run, with a frame in flight ---------------------
        sys_reset    = 1'b1;
        frame_done   = 2'b01;
        frame_errors = {32'd0, 32'd50};
        frame_bits   = {32'd0, 32'd50};
        settle();
        idle();
        check_a_zero("midreset");
        check("midreset snap_cnt", a_cnt, '0);
        sys_reset = 1'b0;
        snapshot();
        settle();
        check("post-reset frames", a_frames, 32'd0);
        check("post-reset cnt",    a_cnt,    16'd1);

        // ---- ACC_W=36 saturation on ch1 (dut_s) ------------------------
        ch_sel = 4'd1;
        for (int i = 0; i < 16; i++) begin
            pulse(2'b10, 0, 0, 32'hFFFF_FFFF, 0);
        end
        pulse(2'b10, 0, 0, 32'd6, 0);
        snapshot();
        settle();
        check("s preload acc_err", s_acc_err, 36'hF_FFFF_FFF6);
        check("s preload sat",     s_sat,     1'b0);
        check("s preload frames",  s_frames,  32'd17);
        pulse(2'b10, 0, 0, 32'd20, 0);
        snapshot();
        settle();
        check("s sat acc_err",  s_acc_err, 36'hF_FFFF_FFFF);
        check("s sat flag",     s_sat,     1'b1);
        check("s last_err",     s_last_err, 32'd20);
        check("a wide acc_err", a_acc_err, 64'h0000_0010_0000_000A);
        check("a wide sat",     a_sat,     1'b0);
        clr = 1'b1;
        settle();
        clr = 1'b0;
        settle();
        check("s clear shadow kept", s_sat, 1'b1);
        snapshot();
        settle();
        check("s cleared acc_err", s_acc_err, 36'h0);
        check("s cleared sat",     s_sat,     1'b0);
        check("s cleared frames",  s_frames,  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
